// File: rtl/station_pkg.sv
// +----------------------------------------------------------------------+
// | station_pkg                                                          |
// | Item codes, sequencer states and item helpers for station_ctrl.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package station_pkg;

  localparam logic [2:0] c_item_none        = 3'd0;
  localparam logic [2:0] c_item_onion       = 3'd1;
  localparam logic [2:0] c_item_onion_cut   = 3'd2;
  localparam logic [2:0] c_item_tomato      = 3'd3;
  localparam logic [2:0] c_item_tomato_cut  = 3'd4;
  localparam logic [2:0] c_item_chicken     = 3'd5;
  localparam logic [2:0] c_item_chicken_cut = 3'd6;
  localparam logic [2:0] c_item_burnt       = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADED  = 2'd1,
    ST_WORKING = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Raw items are the odd codes, except BURNT which shares the low bit.
  function automatic logic is_raw(input logic [2:0] item);
    return item[0] && (item != c_item_burnt);
  endfunction

  function automatic logic [2:0] processed(input logic [2:0] item);
    return item + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// +----------------------------------------------------------------------+
// | tick_prescaler                                                       |
// | Free-running divider: tick pulses on the enabled cycle that wraps.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_prescaler #(
  parameter int TICK_CYCLES = 2500000
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             c_w    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(TICK_CYCLES - 1);

  logic [c_w-1:0] r_count;

  // Combinational so the consumer can act in the same cycle the count wraps.
  assign tick = en && (r_count == c_last);

  always_ff @(posedge clk_25MHz) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? '0 : r_count + c_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/station_ctrl.sv
// +----------------------------------------------------------------------+
// | station_ctrl                                                         |
// | Load / chop / collect sequencer for one food-processing station.     |
// | Optional macro STATION_BURN_EN: items left in DONE eventually burn.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module station_ctrl
  import station_pkg::*;
#(
  parameter int TICK_CYCLES = 2500000,
  parameter int PROG_MAX    = 12,
  parameter int BURN_TICKS  = 50
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       in_station,
  input  logic       btn_pulse,
  input  logic       btn_held,
  input  logic [2:0] hand_item,
  output logic       accept,
  output logic       give,
  output logic [2:0] give_item,
  output logic [6:0] progress,
  output logic [1:0] state,
  output logic       led,
  output logic       burnt
);

  localparam logic [6:0] c_prog_max = 7'(PROG_MAX);

  state_t     r_state;
  logic [2:0] r_held;
  logic [6:0] r_progress;
  logic       r_accept;
  logic       r_give;
  logic [2:0] r_give_item;
  logic       r_led;
  logic       r_burnt;

  logic w_press;
  logic w_empty;
  logic w_work;
  logic w_give;
  logic w_prog_en;
  logic w_tick;
  logic w_burn_en;
  logic w_burn_tick;

  assign w_press = btn_pulse && in_station;
  assign w_empty = (hand_item == c_item_none);
  assign w_work  = (r_state == ST_WORKING) && in_station && btn_held;
  assign w_give  = (r_state == ST_DONE) && w_press && w_empty;

`ifdef STATION_BURN_EN
  // While DONE the progress divider doubles as the burn timebase.
  assign w_prog_en = w_work || (r_state == ST_DONE);
  assign w_burn_en = (r_state == ST_DONE) && w_tick && !r_burnt;
`else
  assign w_prog_en = w_work;
  assign w_burn_en = 1'b0;
`endif

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prog_tick (
    .clk_25MHz(clk_25MHz),
    .reset    (reset),
    .en       (w_prog_en),
    .clr      (w_give),
    .tick     (w_tick)
  );

  tick_prescaler #(
    .TICK_CYCLES(BURN_TICKS)
  ) u_burn_tick (
    .clk_25MHz(clk_25MHz),
    .reset    (reset),
    .en       (w_burn_en),
    .clr      (w_give),
    .tick     (w_burn_tick)
  );

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_held      <= c_item_none;
      r_progress  <= '0;
      r_accept    <= 1'b0;
      r_give      <= 1'b0;
      r_give_item <= c_item_none;
      r_led       <= 1'b0;
      r_burnt     <= 1'b0;
    end else begin
      r_accept    <= 1'b0;
      r_give      <= 1'b0;
      r_give_item <= c_item_none;
      case (r_state)
        ST_IDLE: begin
          if (w_press && is_raw(hand_item)) begin
            r_held   <= hand_item;
            r_accept <= 1'b1;
            r_state  <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (w_press && w_empty) begin
            r_state <= ST_WORKING;
          end
        end
        ST_WORKING: begin
          // A wrap in the same cycle the hold is lost is dropped on purpose.
          if (!(in_station && btn_held)) begin
            r_state <= ST_LOADED;
          end else if (w_tick && (r_progress < c_prog_max)) begin
            r_progress <= r_progress + 7'd1;
            if ((r_progress + 7'd1) == c_prog_max) begin
              r_held  <= processed(r_held);
              r_state <= ST_DONE;
              r_led   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_give) begin
            r_give      <= 1'b1;
            r_give_item <= r_held;
            r_held      <= c_item_none;
            r_progress  <= '0;
            r_led       <= 1'b0;
            r_burnt     <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_burn_tick) begin
            r_held  <= c_item_burnt;
            r_burnt <= 1'b1;
          end
        end
      endcase
    end
  end

  assign accept    = r_accept;
  assign give      = r_give;
  assign give_item = r_give_item;
  assign progress  = r_progress;
  assign state     = r_state;
  assign led       = r_led;
  assign burnt     = r_burnt;

endmodule

`default_nettype wire

// File: tb/tb_station_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_station_ctrl                                                      |
// | Vector table plus directed corner sequences for station_ctrl.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_station_ctrl;

`ifdef STATION_BURN_EN
  localparam bit BURN = 1'b1;
`else
  localparam bit BURN = 1'b0;
`endif

  logic       clk_25MHz = 1'b0;
  logic       reset     = 1'b1;
  logic       in_station = 1'b0;
  logic       btn_pulse  = 1'b0;
  logic       btn_held   = 1'b0;
  logic [2:0] hand_item  = 3'd0;
  logic       accept;
  logic       give;
  logic [2:0] give_item;
  logic [6:0] progress;
  logic [1:0] state;
  logic       led;
  logic       burnt;

  int checks = 0;
  int errors = 0;

  station_ctrl #(
    .TICK_CYCLES(4),
    .PROG_MAX   (3),
    .BURN_TICKS (2)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .in_station(in_station),
    .btn_pulse (btn_pulse),
    .btn_held  (btn_held),
    .hand_item (hand_item),
    .accept    (accept),
    .give      (give),
    .give_item (give_item),
    .progress  (progress),
    .state     (state),
    .led       (led),
    .burnt     (burnt)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  typedef struct {
    logic       rst;
    logic       p;
    logic       h;
    logic       s;
    logic [2:0] hand;
    logic [1:0] st;
    logic [6:0] prog;
    logic       acc;
    logic       gv;
    logic [2:0] gi;
    logic       led;
    logic       chk_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic p, input logic h, input logic s,
                     input logic [2:0] hand, input logic [1:0] st, input logic [6:0] prog,
                     input logic acc, input logic gv, input logic [2:0] gi,
                     input logic ld, input logic chk_st);
    vec_t v;
    v.rst = rst; v.p = p; v.h = h; v.s = s; v.hand = hand;
    v.st = st; v.prog = prog; v.acc = acc; v.gv = gv; v.gi = gi;
    v.led = ld; v.chk_st = chk_st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then settle just past the sampling edge.
  task automatic cyc(input logic rst, input logic p, input logic h, input logic s,
                     input logic [2:0] hand);
    @(negedge clk_25MHz);
    reset = rst; btn_pulse = p; btn_held = h; in_station = s; hand_item = hand;
    @(posedge clk_25MHz);
    #1;
  endtask

  initial begin
    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // IDLE: non-raw, no press, outside station, BURNT all ignored; then onion loads
    add(0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    // LOADED: full hand ignored, empty-hand press starts work
    add(0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 12; k++)
      add(0, 0, 1, 1, 0, (k == 12) ? 2'd3 : 2'd2, 7'(k / 4), 0, 0, 0, (k == 12), 1);
    // DONE: full hand ignored, empty hand collects chopped onion
    add(0, 1, 0, 1, 3, 3, 3, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    // pause / resume with chicken
    add(0, 1, 0, 1, 5, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 6; k++)
      add(0, 0, 1, 1, 0, 2, 7'(k / 4), 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 2, 1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 6; k++)
      add(0, 0, 1, 1, 0, (k == 6) ? 2'd3 : 2'd2, 7'((6 + k) / 4), 0, 0, 0, (k == 6), 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, 1, 6, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].p, vecs[i].h, vecs[i].s, vecs[i].hand);
      chk($sformatf("v%0d.accept", i), accept, vecs[i].acc);
      chk($sformatf("v%0d.give", i), give, vecs[i].gv);
      chk($sformatf("v%0d.give_item", i), give_item, vecs[i].gi);
      chk($sformatf("v%0d.burnt", i), burnt, 0);
      if (vecs[i].chk_st) begin
        chk($sformatf("v%0d.state", i), state, vecs[i].st);
        chk($sformatf("v%0d.progress", i), progress, vecs[i].prog);
        chk($sformatf("v%0d.led", i), led, vecs[i].led);
      end
    end

    // tick wrap coinciding with leaving the station must not count
    cyc(0, 1, 0, 1, 1);
    chk("drop.accept", accept, 1);
    cyc(0, 1, 0, 1, 0);
    chk("drop.state_work", state, 2);
    repeat (3) cyc(0, 0, 1, 1, 0);
    chk("drop.prog_before", progress, 0);
    cyc(0, 0, 1, 0, 0);
    chk("drop.state_loaded", state, 1);
    chk("drop.prog_held", progress, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("drop.prog_resume", progress, 1);
    repeat (4) cyc(0, 0, 1, 1, 0);
    chk("drop.prog_mid", progress, 2);
    repeat (4) cyc(0, 0, 1, 1, 0);
    chk("drop.prog_full", progress, 3);
    chk("drop.state_done", state, 3);

    // sit in DONE: burns after 2 ticks of 4 cycles only when enabled
    repeat (7) cyc(0, 0, 0, 0, 0);
    chk("burn.not_yet", burnt, 0);
    chk("burn.led", led, 1);
    cyc(0, 0, 0, 0, 0);
    chk("burn.flag", burnt, BURN);
    chk("burn.state", state, 3);
    cyc(0, 1, 0, 1, 0);
    chk("burn.give", give, 1);
    chk("burn.give_item", give_item, BURN ? 7 : 2);
    chk("burn.cleared", burnt, 0);
    cyc(0, 0, 0, 1, 0);
    chk("burn.give_off", give, 0);
    chk("burn.idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/station_ctrl.md
Name: station_ctrl

Overview:
- Sequencer for one food-processing station, e.g. the chopping board beside the onion station.
- Consumes the character-in-station flag produced by the station containment checker, plus button pulse/level.
- Accepts a raw item from the player's hand, runs a timed chop while the button is held, and hands back the processed item.
- Drives the progress value used by the station renderer and the station LED.

Parameters:
- TICK_CYCLES, 2500000: clk_25MHz cycles per progress step (0.1 s).
- PROG_MAX, 12: progress steps to finish. Matches station LENGTH so progress maps 1:1 to a bar in pixels. Legal range 1..127.
- BURN_TICKS, 50: steps spent in DONE before the item burns. Used only with STATION_BURN_EN.

Ports:
- clk_25MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_station  in  1  character bounding box is inside the station (combinational, from the checker)
- btn_pulse  in  1  one-cycle debounced press
- btn_held  in  1  debounced button level
- hand_item  in  3  item code currently held by the player
- accept  out  1  one-cycle pulse: station took hand_item (holder clears the hand)
- give  out  1  one-cycle pulse: the player receives give_item
- give_item  out  3  item code handed to the player; valid while give=1, otherwise 0
- progress  out  7  0..PROG_MAX
- state  out  2  IDLE=0, LOADED=1, WORKING=2, DONE=3
- led  out  1  1 while state==DONE
- burnt  out  1  1 when the held item is BURNT (constant 0 without STATION_BURN_EN)

Behaviour:
- Item codes:
  - NONE=0.
  - Raw codes: ONION 1, TOMATO 3, CHICKEN 5.
  - Processed code = raw+1 (2, 4, 6).
  - BURNT=7.
  - A code is raw when it is odd and not 7.
- All outputs are registered; each response appears the cycle after the qualifying input.
- Reset: state=IDLE, held_item=0, progress=0, prescaler=0, accept=give=led=burnt=0, give_item=0. Reset in any state discards the held item.
- IDLE:
  - btn_pulse & in_station & raw(hand_item): held_item<=hand_item, accept=1 for one cycle, go to LOADED.
  - Non-raw or NONE hand: press ignored.
- LOADED:
  - btn_pulse & in_station & hand_item==NONE: go to WORKING. The loading press is consumed, so a new press is required.
  - Press with a non-empty hand: ignored.
  - progress and prescaler are retained from any earlier WORKING period (pause/resume).
- WORKING:
  - Each cycle with in_station & btn_held: prescaler++.
  - At prescaler==TICK_CYCLES-1: prescaler<=0, progress++.
  - If that increment makes progress==PROG_MAX: held_item<=held_item+1 and go to DONE.
  - Any cycle with !in_station | !btn_held: go to LOADED. No increment that cycle, prescaler holds its value.
- DONE:
  - btn_pulse & in_station & hand_item==NONE: give=1 and give_item=held_item for one cycle; then held_item<=0, progress<=0, prescaler<=0, go to IDLE.
  - Press with a non-empty hand: ignored.
- Simultaneous events:
  - accept and give are never asserted together.
  - A tick wrap coinciding with condition loss does not count.
- Widths:
  - prescaler is $clog2(TICK_CYCLES) bits.
  - progress saturates at PROG_MAX and never wraps.

Optional Feature:
- Macro STATION_BURN_EN.
- Defined:
  - In DONE the prescaler keeps running regardless of inputs.
  - A second counter counts ticks.
  - After BURN_TICKS ticks: held_item<=7 and burnt=1.
  - A burnt item is still collected normally, and give clears burnt.
- Undefined: DONE holds indefinitely and burnt is tied 0.

Decomposition:
- Package station_pkg holds:
  - item code localparams (NONE..BURNT);
  - state encodings;
  - an is_raw(item) function;
  - a processed(item) function.
- One sub-module, tick_prescaler, with ports clk_25MHz, reset, en, clr, tick. It is instantiated for the progress tick and reused for the burn timer.

Test Plan (TICK_CYCLES=4, PROG_MAX=3, BURN_TICKS=2):
- Reset for 2 cycles -> state=0, progress=0, accept=give=led=burnt=0, give_item=0.
- IDLE, in_station=1, hand_item=2, pulse -> no accept. Then hand_item=1, pulse -> accept=1 for exactly one cycle, state=1.
- LOADED, hand_item=0, pulse, then btn_held=1 for 12 cycles -> progress=1, 2, 3 on the 4th, 8th and 12th held cycles; state=3, led=1.
- Same as above but drop btn_held after 6 held cycles -> progress=1, state=1 with prescaler held at 2. Re-press and hold 6 cycles -> progress=3, state=3.
- DONE, hand_item=3, pulse -> ignored. Then hand_item=0, pulse -> give=1 with give_item=2; next cycle state=0, progress=0, led=0.
- With STATION_BURN_EN, idle 8 cycles in DONE -> burnt=1. Then pulse with empty hand -> give_item=7, burnt clears.
